location_tracker: RTL

- Episode-aware agent position tracker for the Dyna-Q grid-world datapath; the parametrised successor of the plain start/next location register.
- Takes a start location, then applies 4-way actions itself: computes the next cell, clamps at grid edges, counts steps, and detects goal or step-limit to end the episode.
- Feeds the current/previous state, action and step info to the Q-table update and model-learning stages.

---
 rtl/location_tracker_pkg.sv | 23 ++
 rtl/grid_step_calc.sv | 40 ++++
 rtl/location_tracker.sv | 115 +++++++++++
 3 files changed

// File: rtl/location_tracker_pkg.sv
// Shared encodings for the Dyna-Q location tracker: actions, tracker states
// and the per-move status flags.
package location_tracker_pkg;

    localparam logic [1:0] ACT_UP    = 2'd0;
    localparam logic [1:0] ACT_DOWN  = 2'd1;
    localparam logic [1:0] ACT_LEFT  = 2'd2;
    localparam logic [1:0] ACT_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tracker_state_t;

    typedef struct packed {
        logic moved;
        logic bumped;
        logic at_goal;
        logic ended;
    } move_flags_t;

endpackage

// File: rtl/grid_step_calc.sv
// Combinational next-cell computation for a 4-way grid move; a move that
// would leave the grid keeps the cell and raises bumped.
module grid_step_calc
    import location_tracker_pkg::*;
#(
    parameter int ROW_BITS = 3,
    parameter int COL_BITS = 3,
    parameter int GRID_H   = 8,
    parameter int GRID_W   = 8
) (
    input  logic [ROW_BITS+COL_BITS-1:0] location,
    input  logic [1:0]                   action,
    output logic [ROW_BITS+COL_BITS-1:0] next_location,
    output logic                         bumped
);

    // One extra bit so GRID_H-1 == 2**ROW_BITS-1 still compares cleanly.
    localparam logic [ROW_BITS:0] ROW_LAST = (ROW_BITS+1)'(GRID_H - 1);
    localparam logic [COL_BITS:0] COL_LAST = (COL_BITS+1)'(GRID_W - 1);

    logic [ROW_BITS-1:0] row, row_n;
    logic [COL_BITS-1:0] col, col_n;

    assign {row, col} = location;

    always_comb begin
        row_n  = row;
        col_n  = col;
        bumped = 1'b0;
        case (action)
            ACT_UP:    if (row != '0)                 row_n = row - 1'b1; else bumped = 1'b1;
            ACT_DOWN:  if ({1'b0, row} < ROW_LAST)    row_n = row + 1'b1; else bumped = 1'b1;
            ACT_LEFT:  if (col != '0)                 col_n = col - 1'b1; else bumped = 1'b1;
            default:   if ({1'b0, col} < COL_LAST)    col_n = col + 1'b1; else bumped = 1'b1;
        endcase
    end

    assign next_location = {row_n, col_n};

endmodule

// File: rtl/location_tracker.sv
// Episode-aware agent position tracker: loads a start cell, applies actions
// with edge clamping, counts steps and ends the episode on goal or step limit.
module location_tracker
    import location_tracker_pkg::*;
#(
    parameter int ROW_BITS    = 3,
    parameter int COL_BITS    = 3,
    parameter int DATA_LENGTH = ROW_BITS + COL_BITS,
    parameter int GRID_H      = 8,
    parameter int GRID_W      = 8,
    parameter int STEP_BITS   = 8,
    parameter int MAX_STEPS   = 200
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_valid,
    input  logic [DATA_LENGTH-1:0] start_location,
    input  logic [DATA_LENGTH-1:0] goal_location,
    input  logic                   action_valid,
    input  logic [1:0]             action,
    output logic                   action_ready,
    output logic [DATA_LENGTH-1:0] current_location,
    output logic [DATA_LENGTH-1:0] prev_location,
    output logic [1:0]             last_action,
    output logic [STEP_BITS-1:0]   step_count,
    output logic                   move_done,
    output logic                   bumped,
    output logic                   at_goal,
    output logic                   episode_done,
    output logic                   start_err
);

    localparam logic [ROW_BITS:0]    ROW_CNT    = (ROW_BITS+1)'(GRID_H);
    localparam logic [COL_BITS:0]    COL_CNT    = (COL_BITS+1)'(GRID_W);
    localparam logic [STEP_BITS-1:0] STEP_LIMIT = STEP_BITS'(MAX_STEPS);

    tracker_state_t         state, state_n;
    logic                   start_ok, accept;
    logic [DATA_LENGTH-1:0] next_cell;
    logic                   step_bumped;
    logic [STEP_BITS-1:0]   step_inc;
    move_flags_t            flags_n, flags;

    grid_step_calc #(
        .ROW_BITS (ROW_BITS),
        .COL_BITS (COL_BITS),
        .GRID_H   (GRID_H),
        .GRID_W   (GRID_W)
    ) u_step (
        .location      (current_location),
        .action        (action),
        .next_location (next_cell),
        .bumped        (step_bumped)
    );

    assign start_ok = ({1'b0, start_location[DATA_LENGTH-1:COL_BITS]} < ROW_CNT) &&
                      ({1'b0, start_location[COL_BITS-1:0]} < COL_CNT);
    assign action_ready = (state == ST_RUN);
    assign accept       = action_valid && action_ready && !start_valid;
    assign step_inc     = step_count + 1'b1;

    always_comb begin
        flags_n.moved   = accept;
        flags_n.bumped  = accept && step_bumped;
        flags_n.at_goal = accept && (next_cell == goal_location);
        flags_n.ended   = accept && ((next_cell == goal_location) || (step_inc == STEP_LIMIT));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_n;
    end

    // A start request wins over everything, valid or not; a rejected start leaves the state alone.
    always_comb begin
        state_n = state;
        if (start_valid) begin
            if (start_ok) state_n = ST_RUN;
        end else if (flags_n.ended) begin
            state_n = ST_DONE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            current_location <= '0;
            prev_location    <= '0;
            last_action      <= '0;
            step_count       <= '0;
            flags            <= '0;
            start_err        <= 1'b0;
        end else begin
            flags     <= flags_n;
            start_err <= start_valid && !start_ok;
            if (start_valid) begin
                if (start_ok) begin
                    current_location <= start_location;
                    prev_location    <= start_location;
                    step_count       <= '0;
                end
            end else if (accept) begin
                prev_location    <= current_location;
                current_location <= next_cell;
                last_action      <= action;
                step_count       <= step_inc;
            end
        end
    end

    assign move_done    = flags.moved;
    assign bumped       = flags.bumped;
    assign at_goal      = flags.at_goal;
    assign episode_done = flags.ended;

endmodule
